// File: rtl/reg_file_sb_if.sv
// Issue, read and writeback bundle between decode/wb and the register file.
// Master drives requests; slave returns operands, stall and pending state.
interface reg_file_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic             rs1_used;
  logic             rs2_used;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic             issue_valid;
  logic [4:0]       issue_rd;
  logic             stall;
  logic             wb_valid;
  logic [4:0]       wb_addr;
  logic [XLEN-1:0]  wb_data;
  logic [NREGS-1:0] pending_vec;

  modport master (
    output rs1_addr,
    output rs2_addr,
    output rs1_used,
    output rs2_used,
    output issue_valid,
    output issue_rd,
    output wb_valid,
    output wb_addr,
    output wb_data,
    input  rs1_data,
    input  rs2_data,
    input  stall,
    input  pending_vec
  );

  modport slave (
    input  rs1_addr,
    input  rs2_addr,
    input  rs1_used,
    input  rs2_used,
    input  issue_valid,
    input  issue_rd,
    input  wb_valid,
    input  wb_addr,
    input  wb_data,
    output rs1_data,
    output rs2_data,
    output stall,
    output pending_vec
  );
endinterface

// File: rtl/reg_file_sb.sv
// Integer register file with a pending-write scoreboard.
// Reads are combinational with optional writeback forwarding.
module reg_file_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter bit BYPASS = 1'b1
) (
  input logic          clk,
  input logic          rst,
  reg_file_sb_if.slave bus
);

  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [XLEN-1:0]  rf [NREGS];
  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_d;

  logic             wb_en;
  logic             set_en;
  logic             hit1;
  logic             hit2;
  logic             hit_rd;
  logic             p1;
  logic             p2;
  logic             p_rd;
  logic             raw1;
  logic             raw2;
  logic             waw;
  logic             stall;

  // Index zero and indices beyond NREGS never hold state.
  function automatic logic live(input logic [4:0] a);
    return (a != 5'd0) && (int'(a) < NREGS);
  endfunction

  function automatic logic [AW-1:0] idx(input logic [4:0] a);
    return a[AW-1:0];
  endfunction

  function automatic logic wb_hit(input logic [4:0] a);
    return BYPASS && bus.wb_valid && (bus.wb_addr == a);
  endfunction

  function automatic logic pend_at(
    input logic [NREGS-1:0] pv,
    input logic [4:0]       a
  );
    return live(a) && pv[idx(a)];
  endfunction

  // Writeback and forwarding hit terms.
  always_comb begin
    wb_en  = bus.wb_valid && live(bus.wb_addr);
    hit1   = wb_hit(bus.rs1_addr);
    hit2   = wb_hit(bus.rs2_addr);
    hit_rd = wb_hit(bus.issue_rd);
  end

  // Operand 1: forwarded wb data, stored value, or zero.
  always_comb begin
    bus.rs1_data = '0;
    if (live(bus.rs1_addr)) begin
      if (hit1)
        bus.rs1_data = bus.wb_data;
      else
        bus.rs1_data = rf[idx(bus.rs1_addr)];
    end
  end

  // Operand 2: forwarded wb data, stored value, or zero.
  always_comb begin
    bus.rs2_data = '0;
    if (live(bus.rs2_addr)) begin
      if (hit2)
        bus.rs2_data = bus.wb_data;
      else
        bus.rs2_data = rf[idx(bus.rs2_addr)];
    end
  end

  // Hazard detection against outstanding writes.
  always_comb begin
    p1    = pend_at(pend_q, bus.rs1_addr);
    p2    = pend_at(pend_q, bus.rs2_addr);
    p_rd  = pend_at(pend_q, bus.issue_rd);
    raw1  = bus.rs1_used && p1 && !hit1;
    raw2  = bus.rs2_used && p2 && !hit2;
    waw   = p_rd && !hit_rd;
    stall = bus.issue_valid && (raw1 || raw2 || waw);
  end

  assign bus.stall = stall;

  // Next scoreboard: clear on writeback, then set on issue so
  // a same-cycle new producer keeps the bit high.
  always_comb begin
    set_en = bus.issue_valid && !stall && live(bus.issue_rd);
    pend_d = pend_q;
    if (wb_en)
      pend_d[idx(bus.wb_addr)] = 1'b0;
    if (set_en)
      pend_d[idx(bus.issue_rd)] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pend_q <= '0;
    else
      pend_q <= pend_d;
  end

  assign bus.pending_vec = pend_q;

  // Register storage; x0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        rf[i] <= '0;
    end else if (wb_en) begin
      rf[idx(bus.wb_addr)] <= bus.wb_data;
    end
  end

endmodule
